// File: rtl/wrr_grant_scheduler.sv
// wrr_grant_scheduler: four-requester weighted round-robin owner of a shared bus.
// Each grant lasts at most the requester's remaining credit. Priority rotates past the
// last owner. Credits are refilled from shadow weights when nobody eligible is left.
// Optional feature macro: WRR_LOCK_EN adds a 'lock' input. While lock is high, a held
// grant survives credit exhaustion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; pick winner, or reload credits (frame boundary)
// HOLD  | one requester owns the bus; burn credit until release
module wrr_grant_scheduler #(
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          done,
  input  logic [WEIGHT_W-1:0] weight_0,
  input  logic [WEIGHT_W-1:0] weight_1,
  input  logic [WEIGHT_W-1:0] weight_2,
  input  logic [WEIGHT_W-1:0] weight_3,
  input  logic                cfg_load,
`ifdef WRR_LOCK_EN
  input  logic                lock,
`endif
  output logic [3:0]          grant,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic                frame_end
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [WEIGHT_W-1:0] r_credit [4];
  logic [WEIGHT_W-1:0] r_shadow [4];
  logic [3:0]          r_grant;
  logic [1:0]          r_grant_id;
  logic                r_busy;
  logic                r_frame_end;

  logic [WEIGHT_W-1:0] w_weight [4];
  logic [3:0]          w_elig;
  logic                w_reload_ok;
  logic                w_win_found;
  logic [1:0]          w_win_idx;
  logic [WEIGHT_W-1:0] w_cur_credit;
  logic                w_lock;
  logic                w_release;

  assign w_weight[0] = weight_0;
  assign w_weight[1] = weight_1;
  assign w_weight[2] = weight_2;
  assign w_weight[3] = weight_3;

`ifdef WRR_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Eligibility and reload qualification per requester.
  always_comb begin
    w_elig      = '0;
    w_reload_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = req[i] && (r_credit[i] != '0);
      if (req[i] && (r_shadow[i] != '0)) w_reload_ok = 1'b1;
    end
  end

  // Rotating search starting at r_ptr; the lowest offset that is eligible wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_elig[r_ptr + 2'(k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = r_ptr + 2'(k);
      end
    end
  end

  // Release decision for the current owner; with lock, exhaustion alone cannot release.
  always_comb begin
    w_cur_credit = r_credit[r_grant_id];
    w_release    = done[r_grant_id] || !req[r_grant_id] ||
                   ((w_cur_credit == WEIGHT_W'(1)) && !w_lock);
  end

  // Scheduler FSM, credits, shadow weights and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_grant     <= 4'd0;
      r_grant_id  <= 2'd0;
      r_busy      <= 1'b0;
      r_frame_end <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_credit[i] <= '0;
        r_shadow[i] <= WEIGHT_W'(1);
      end
    end else begin
      // New weights land in the shadow now but only reach credits at the next reload.
      if (cfg_load) begin
        for (int i = 0; i < 4; i++) r_shadow[i] <= w_weight[i];
      end
      r_frame_end <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_grant    <= 4'b0001 << w_win_idx;
            r_grant_id <= w_win_idx;
            r_busy     <= 1'b1;
            r_state    <= ST_HOLD;
          end else if (w_reload_ok) begin
            for (int i = 0; i < 4; i++) r_credit[i] <= r_shadow[i];
            r_frame_end <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_cur_credit != '0) r_credit[r_grant_id] <= w_cur_credit - WEIGHT_W'(1);
          if (w_release) begin
            r_grant    <= 4'd0;
            r_grant_id <= 2'd0;
            r_busy     <= 1'b0;
            r_ptr      <= r_grant_id + 2'd1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign frame_end = r_frame_end;

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// tb_wrr_grant_scheduler: directed sequences plus random traffic against a
// cycle-level reference of the scheduling rules (owner index, credit array, pointer).
module tb_wrr_grant_scheduler;

`ifdef WRR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] w [4];
  logic       cfg_load;
  logic       lock;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       frame_end;

  int n_total;
  int n_bad;

  // reference state
  int m_cred [4];
  int m_shadow [4];
  int m_ptr;
  int m_owner;
  bit m_fe;

  int exp_g [$];
  int exp_f [$];
  int drv_done [$];

  wrr_grant_scheduler #(.WEIGHT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .weight_0 (w[0]),
    .weight_1 (w[1]),
    .weight_2 (w[2]),
    .weight_3 (w[3]),
    .cfg_load (cfg_load),
`ifdef WRR_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .frame_end(frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge of the scheduling rules, using the inputs present at that edge.
  task automatic model_step();
    int nsh [4];
    int pick;
    int c;
    int o;
    bit any_reload;
    bit lk;
    lk = LOCK_EN && lock;
    for (int i = 0; i < 4; i++) nsh[i] = cfg_load ? int'(w[i]) : m_shadow[i];
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_fe    = 0;
      for (int i = 0; i < 4; i++) begin
        m_cred[i]   = 0;
        m_shadow[i] = 1;
      end
      return;
    end
    m_fe = 0;
    if (m_owner < 0) begin
      pick = -1;
      for (int k = 0; k < 4; k++) begin
        o = (m_ptr + k) % 4;
        if (pick < 0 && req[o] && m_cred[o] > 0) pick = o;
      end
      if (pick >= 0) begin
        m_owner = pick;
      end else begin
        any_reload = 0;
        for (int i = 0; i < 4; i++) if (req[i] && m_shadow[i] > 0) any_reload = 1;
        if (any_reload) begin
          for (int i = 0; i < 4; i++) m_cred[i] = m_shadow[i];
          m_fe = 1;
        end
      end
    end else begin
      o = m_owner;
      c = m_cred[o];
      if (c > 0) m_cred[o] = c - 1;
      if (done[o] || !req[o] || (c == 1 && !lk)) begin
        m_owner = -1;
        m_ptr   = (o + 1) % 4;
      end
    end
    for (int i = 0; i < 4; i++) m_shadow[i] = nsh[i];
  endtask

  // Advance one edge, then compare every output against the reference.
  task automatic tick();
    logic [7:0] exp_v;
    @(posedge clk);
    model_step();
    #1;
    exp_v = (m_owner >= 0) ? {4'(1 << m_owner), 2'(m_owner), 1'b1, m_fe}
                           : {4'd0, 2'd0, 1'b0, m_fe};
    chk("cycle_model", {grant, grant_id, busy, frame_end}, exp_v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    done = 4'd0;
    cfg_load = 1'b0;
    lock = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_weights(input int a, input int b, input int c, input int d);
    w[0] = 4'(a); w[1] = 4'(b); w[2] = 4'(c); w[3] = 4'(d);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic run_seq(input string tag);
    for (int i = 0; i < exp_g.size(); i++) begin
      done = (i < drv_done.size()) ? 4'(drv_done[i]) : 4'd0;
      tick();
      chk($sformatf("%s_grant%0d", tag, i), grant, exp_g[i]);
      chk($sformatf("%s_fe%0d", tag, i), frame_end, exp_f[i]);
    end
    done = 4'd0;
  endtask

  initial begin
    int cnt;
    int guard;
    n_total = 0;
    n_bad = 0;
    m_owner = -1;
    m_ptr = 0;
    m_fe = 0;
    for (int i = 0; i < 4; i++) begin
      m_cred[i] = 0;
      m_shadow[i] = 1;
      w[i] = 4'd1;
    end
    rst = 1'b1; req = 4'hF; done = 4'd0; cfg_load = 1'b0; lock = 1'b0;

    // reset held two edges with all requesting
    tick();
    tick();
    chk("rst_outputs", {grant, grant_id, busy, frame_end}, 8'd0);
    rst = 1'b0;
    tick();
    chk("rst_reload_fe", frame_end, 1);
    chk("rst_reload_nogrant", grant, 0);
    tick();
    chk("rst_first_grant", grant, 4'b0001);
    chk("rst_first_busy", busy, 1);

    // single requester, weight 3
    do_reset();
    load_weights(1, 3, 1, 1);
    req = 4'b0010;
    exp_g = '{0, 2, 2, 2, 0, 0, 2, 2, 2, 0, 0, 2, 2, 2};
    exp_f = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    drv_done = {};
    run_seq("single");

    // all requesters, weights 1..4
    do_reset();
    load_weights(1, 2, 3, 4);
    req = 4'hF;
    exp_g = '{0, 1, 0, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 8, 0, 0, 1, 0, 2, 2};
    exp_f = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    run_seq("wrr1234");

    // early release keeps leftover credit within the frame
    do_reset();
    load_weights(1, 1, 4, 1);
    req = 4'b0100;
    exp_g = '{0, 4, 4, 0, 4, 4, 0, 0, 4, 4, 4, 4, 0};
    exp_f = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    drv_done = '{0, 0, 0, 4};
    run_seq("early");
    drv_done = {};

    // weight 0 disables requester 3
    do_reset();
    load_weights(1, 1, 1, 0);
    req = 4'hF;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant[3]) cnt++;
    end
    chk("w0_grant3_count", cnt, 0);
    req = 4'b1000;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_end) cnt++;
    end
    chk("w0_fe_count", cnt, 0);
    chk("w0_idle_grant", grant, 0);

    // reset in the middle of a 4-cycle grant
    do_reset();
    load_weights(4, 4, 4, 4);
    req = 4'hF;
    guard = 0;
    while (grant != 4'b0010 && guard < 50) begin
      tick();
      guard++;
    end
    chk("midhold_reached", grant, 4'b0010);
    tick();
    rst = 1'b1;
    tick();
    chk("midhold_rst_grant", grant, 0);
    chk("midhold_rst_busy", busy, 0);
    rst = 1'b0;
    guard = 0;
    tick();
    while (grant == 4'd0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("midhold_next_grant", grant, 4'b0001);

`ifdef WRR_LOCK_EN
    // lock keeps an exhausted grant until done
    do_reset();
    load_weights(1, 1, 1, 1);
    lock = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    chk("lock_grant_start", grant, 4'b0001);
    repeat (6) tick();
    chk("lock_grant_held", grant, 4'b0001);
    done = 4'b0001;
    tick();
    chk("lock_released", grant, 0);
    done = 4'd0;
    lock = 1'b0;
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (req ^ 4'(1 << $urandom_range(0, 3)));
      if ($urandom_range(0, 5) == 0) req = 4'hF;
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      cfg_load = ($urandom_range(0, 39) == 0);
      if (cfg_load) begin
        for (int i = 0; i < 4; i++) w[i] = 4'($urandom_range(0, 6));
      end
      lock = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    cfg_load = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
